// File: rtl/ddr_loader_pkg.sv
// Shared types and AXI constants for the burst loader: FSM state encoding,
// burst/response codes and the AxSIZE encoding helper.
package ddr_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } loader_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // AxSIZE is log2 of the bytes per beat
    function automatic logic [2:0] axi_size(input int data_w);
        logic [2:0] size;
        case (data_w)
            8:       size = 3'd0;
            16:      size = 3'd1;
            32:      size = 3'd2;
            64:      size = 3'd3;
            128:     size = 3'd4;
            default: size = 3'd2;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/loader_fifo.sv
// Show-ahead FIFO with occupancy count; the head word is always visible on
// data_o so the write channel can present it the same cycle it is popped.
module loader_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    always_comb begin
        do_push  = push_i && (count_q != CW'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/axi_burst_loader.sv
// Streams frames into a ring of memory buffers as INCR write bursts, one
// burst in flight at a time, with the stream decoupled by a two-burst FIFO.
module axi_burst_loader
    import ddr_loader_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int BURST_LEN = 16,
    parameter int NUM_BUFS  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_W-1:0]     cfg_base_addr_i,
    input  logic [ADDR_W-1:0]     cfg_buf_stride_i,
    input  logic [23:0]           cfg_frame_words_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  err_o,
    output logic [1:0]            buf_idx_o,
    input  logic [DATA_W-1:0]     s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [ID_W-1:0]       m_awid,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [ID_W-1:0]       m_bid,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    localparam int         DEPTH       = 2 * BURST_LEN;
    localparam int         CW          = $clog2(DEPTH + 1);
    localparam logic [2:0] AXSIZE      = axi_size(DATA_W);
    localparam logic [8:0] BURST_BEATS = 9'(BURST_LEN);

    loader_state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [23:0]       frame_words_q, frame_words_d;
    logic [23:0]       accepted_q, accepted_d;
    logic [23:0]       remaining_q, remaining_d;
    logic [8:0]        burst_beats_q, burst_beats_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic [1:0]        buf_idx_q, buf_idx_d;
    logic              err_q, err_d;
    logic              frame_done_q, frame_done_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] fifo_data;
    logic [8:0]        need_beats;
    logic [7:0]        cur_awlen;
    logic [1:0]        next_buf;

    loader_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (fifo_push),
        .data_i  (s_data_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .count_o (fifo_count),
        .full_o  (fifo_full)
    );

    // Stream is throttled to exactly the frame length so the FIFO drains empty
    assign s_ready_o = (state_q != ST_IDLE) && !fifo_full && (accepted_q < frame_words_q);
    assign fifo_push = s_valid_i && s_ready_o;
    assign fifo_pop  = m_wvalid && m_wready;

    assign need_beats = (remaining_q >= 24'(BURST_LEN)) ? BURST_BEATS : remaining_q[8:0];
    assign cur_awlen  = 8'(burst_beats_q - 9'd1);
    assign next_buf   = (buf_idx_q == 2'(NUM_BUFS - 1)) ? 2'd0 : buf_idx_q + 2'd1;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        frame_words_d = frame_words_q;
        accepted_d    = accepted_q;
        remaining_d   = remaining_q;
        burst_beats_d = burst_beats_q;
        beat_cnt_d    = beat_cnt_q;
        buf_idx_d     = buf_idx_q;
        err_d         = err_q;
        frame_done_d  = 1'b0;

        if (fifo_push) begin
            accepted_d = accepted_q + 24'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (cfg_frame_words_i == '0) begin
                        frame_done_d = 1'b1;
                        buf_idx_d    = next_buf;
                    end else begin
                        state_d       = ST_WAIT_DATA;
                        frame_words_d = cfg_frame_words_i;
                        remaining_d   = cfg_frame_words_i;
                        accepted_d    = '0;
                        addr_d        = cfg_base_addr_i + ADDR_W'(buf_idx_q) * cfg_buf_stride_i;
                    end
                end
            end
            ST_WAIT_DATA: begin
                // Hold off the address until the whole burst is buffered so
                // the write channel never stalls on the stream
                if (32'(fifo_count) >= 32'(need_beats)) begin
                    burst_beats_d = need_beats;
                    beat_cnt_d    = '0;
                    state_d       = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_awready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_wready) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == cur_awlen) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (m_bvalid) begin
                    // A response carrying a foreign ID is treated as an error too
                    if ((m_bresp != RESP_OKAY) || (m_bid != '0)) begin
                        err_d = 1'b1;
                    end
                    addr_d      = addr_q + (ADDR_W'(burst_beats_q) << AXSIZE);
                    remaining_d = remaining_q - 24'(burst_beats_q);
                    if (remaining_d == '0) begin
                        state_d      = ST_IDLE;
                        frame_done_d = 1'b1;
                        buf_idx_d    = next_buf;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            frame_words_q <= '0;
            accepted_q    <= '0;
            remaining_q   <= '0;
            burst_beats_q <= '0;
            beat_cnt_q    <= '0;
            buf_idx_q     <= '0;
            err_q         <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            frame_words_q <= frame_words_d;
            accepted_q    <= accepted_d;
            remaining_q   <= remaining_d;
            burst_beats_q <= burst_beats_d;
            beat_cnt_q    <= beat_cnt_d;
            buf_idx_q     <= buf_idx_d;
            err_q         <= err_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // All AXI valids/readies decode from the state register only
    assign m_awid       = '0;
    assign m_awaddr     = addr_q;
    assign m_awlen      = cur_awlen;
    assign m_awsize     = AXSIZE;
    assign m_awburst    = BURST_INCR;
    assign m_awvalid    = (state_q == ST_ADDR);
    assign m_wdata      = fifo_data;
    assign m_wstrb      = '1;
    assign m_wvalid     = (state_q == ST_DATA);
    assign m_wlast      = (state_q == ST_DATA) && (beat_cnt_q == cur_awlen);
    assign m_bready     = (state_q == ST_RESP);

    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = frame_done_q;
    assign err_o        = err_q;
    assign buf_idx_o    = buf_idx_q;

endmodule
